micro_op_queue: RTL

Parametrised decode queue between the micro-op fetch/expansion stage and the issue stage. Each cycle it accepts one bundle of `IN_N` micro-op slots and removes NOP holes anywhere in the bundle. The surviving ops are written, in slot order, into a `DEPTH`-entry circular buffer. The issue stage sees an `OUT_N`-wide in-order head window and retires 0..`OUT_N` entries per cycle.

---
 rtl/micro_op_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/micro_op_queue.sv
// Decode queue: compacts NOP holes out of each fetch bundle into a circular buffer
// and presents an in-order head window to the issue stage.
module micro_op_queue #(
    parameter int IN_N      = 4,
    parameter int OUT_N     = 2,
    parameter int DEPTH     = 8,
    parameter int OP_W      = 8,
    parameter int PAYLOAD_W = 96,
    parameter logic [OP_W-1:0] NOP_CODE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IN_N*OP_W-1:0]                 fet_opcode,
    input  logic [IN_N*PAYLOAD_W-1:0]            fet_payload,
    input  logic                                 fet_valid,
    output logic                                 fet_ready,
    output logic [OUT_N*OP_W-1:0]                deq_opcode,
    output logic [OUT_N*PAYLOAD_W-1:0]           deq_payload,
    output logic [OUT_N-1:0]                     deq_valid,
    input  logic [$clog2(OUT_N+1)-1:0]           deq_pop_n,
    output logic [$clog2(DEPTH+1)-1:0]           deq_count,
    input  logic                                 flush
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        count;
    logic [OP_W-1:0]      mem_op  [DEPTH];
    logic [PAYLOAD_W-1:0] mem_pay [DEPTH];

    logic [IN_N-1:0]      live;
    logic [PW-1:0]        slot_idx [IN_N];
    logic [CW-1:0]        k;
    logic [CW-1:0]        pop_req, pops;
    logic                 push;

    // Each live slot lands at tail plus the number of live slots before it.
    always_comb begin
        k    = '0;
        live = '0;
        for (int unsigned i = 0; i < IN_N; i++) begin
            slot_idx[i] = tail + k[PW-1:0];
            live[i]     = (fet_opcode[i*OP_W +: OP_W] != NOP_CODE);
            k           = k + CW'(live[i]);
        end
    end

    assign fet_ready = (count <= CW'(DEPTH - IN_N));
    assign push      = fet_valid & fet_ready & ~flush;
    assign pop_req   = CW'(deq_pop_n);
    assign pops      = (pop_req > count) ? count : pop_req;
    assign deq_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + k[PW-1:0];
            head  <= head + pops[PW-1:0];
            count <= count + (push ? k : CW'(0)) - pops;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < IN_N; i++) begin
                if (live[i]) begin
                    mem_op[slot_idx[i]]  <= fet_opcode[i*OP_W +: OP_W];
                    mem_pay[slot_idx[i]] <= fet_payload[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    always_comb begin
        deq_opcode  = {OUT_N{NOP_CODE}};
        deq_payload = '0;
        deq_valid   = '0;
        for (int unsigned w = 0; w < OUT_N; w++) begin
            if (CW'(w) < count) begin
                deq_valid[w]                         = 1'b1;
                deq_opcode[w*OP_W +: OP_W]           = mem_op[head + PW'(w)];
                deq_payload[w*PAYLOAD_W +: PAYLOAD_W] = mem_pay[head + PW'(w)];
            end
        end
    end

endmodule
